// File: rtl/sync_bit_handshake_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack bit-synchronizer crossing
// among NREQ source-domain requesters, with ack timeout and stuck-ack detection.
module sync_bit_handshake_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IW      = 2,
   parameter int unsigned CW      = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQ,
   input  logic            ACK,
   output logic            SYNC_EN,
   output logic            SYNC_D,
   output logic            BUSY,
   output logic [IW-1:0]   OWNER,
   output logic            DONE,
   output logic            DONE_ERR,
   output logic            STUCK
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAISE   = 3'd1,
      WAIT_HI = 3'd2,
      DROP    = 3'd3,
      WAIT_LO = 3'd4,
      FAULT   = 3'd5
   } state_t;

   state_t          state, state_n;
   logic [IW-1:0]   ptr, ptr_n;
   logic [IW-1:0]   owner_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [CW-1:0]   cnt_inc;
   logic            timeout_hit;
   logic            err, err_n;
   logic            sync_d_n;
   logic            done_n;
   logic            done_err_n;
   logic            grant_vld;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand;

   // Index addition modulo NREQ; both operands are below NREQ so one subtract suffices.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // Round-robin pick: first set request scanning upward from the pointer, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = wrap_add(ptr, i);
         if (!grant_vld && REQ[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign cnt_inc     = cnt + CW'(1);
   assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

   // Next-state and next-output decode for the handshake sequencer.
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      owner_n    = OWNER;
      cnt_n      = cnt;
      err_n      = err;
      sync_d_n   = SYNC_D;
      done_n     = 1'b0;
      done_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               owner_n  = grant_idx;
               err_n    = 1'b0;
               cnt_n    = '0;
               sync_d_n = 1'b1;
               state_n  = RAISE;
            end
         end
         RAISE: begin
            cnt_n   = '0;
            state_n = WAIT_HI;
         end
         WAIT_HI: begin
            if (ACK) begin
               sync_d_n = 1'b0;
               state_n  = DROP;
            end else begin
               cnt_n = cnt_inc;
               if (timeout_hit) begin
                  err_n    = 1'b1;
                  sync_d_n = 1'b0;
                  state_n  = DROP;
               end
            end
         end
         DROP: begin
            cnt_n   = '0;
            state_n = WAIT_LO;
         end
         WAIT_LO: begin
            if (!ACK) begin
               done_n     = 1'b1;
               done_err_n = err;
               ptr_n      = wrap_add(OWNER, 1);
               state_n    = IDLE;
            end else begin
               cnt_n = cnt_inc;
               if (timeout_hit) state_n = FAULT;
            end
         end
         FAULT: begin
            sync_d_n = 1'b0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset forces everything, including SYNC_D, low at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         ptr      <= '0;
         OWNER    <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         SYNC_D   <= 1'b0;
         SYNC_EN  <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         DONE_ERR <= 1'b0;
         STUCK    <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         OWNER    <= owner_n;
         cnt      <= cnt_n;
         err      <= err_n;
         SYNC_D   <= sync_d_n;
         SYNC_EN  <= (state_n == RAISE) || (state_n == DROP);
         BUSY     <= (state_n != IDLE);
         DONE     <= done_n;
         DONE_ERR <= done_err_n;
         STUCK    <= (state_n == FAULT);
      end
   end

endmodule

// File: tb/tb_sync_bit_handshake_arbiter.sv
// Scoreboard bench for sync_bit_handshake_arbiter: stimulus queues expected
// completions, a DONE monitor pops and compares them.
module tb_sync_bit_handshake_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TO   = 5;

   logic       CLK;
   logic       RST;
   logic [3:0] req;
   logic       ack;
   logic       sync_en, sync_d, busy, done, done_err, stuck;
   logic [1:0] owner;

   int checks = 0;
   int errors = 0;
   int sb_q[$];
   int en_cnt = 0;
   int hi_cnt = 0;
   int mode   = 1;   // 0 echo, 1 tie low, 2 echo then hold high, 3 manual
   logic p0 = 1'b0;
   logic p1 = 1'b0;

   sync_bit_handshake_arbiter #(.NREQ(NREQ), .IW(2), .CW(8), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .REQ(req), .ACK(ack),
      .SYNC_EN(sync_en), .SYNC_D(sync_d), .BUSY(busy), .OWNER(owner),
      .DONE(done), .DONE_ERR(done_err), .STUCK(stuck)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Ack responder: models the far side echoing SYNC_D through two sync stages.
   initial begin
      forever begin
         @(negedge CLK);
         case (mode)
            0: begin ack = p1; p1 = p0; p0 = sync_d; end
            1: begin ack = 1'b0; p1 = 1'b0; p0 = 1'b0; end
            2: begin ack = ack | p1; p1 = p0; p0 = sync_d; end
            default: ;
         endcase
      end
   end

   // Monitor: compare each DONE pulse against the queued expectation, and count activity.
   initial begin
      int e;
      forever begin
         @(negedge CLK);
         if (sync_en) en_cnt++;
         if (busy && sync_d && !sync_en) hi_cnt++;
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("done_owner", int'(owner), e / 2);
               chk("done_err", int'(done_err), e % 2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done(input int n);
      bit got;
      got = 1'b0;
      for (int i = 0; i < n && !got; i++) begin
         tick();
         if (done) got = 1'b1;
      end
      chk("done_seen", int'(got), 1);
   endtask

   // Queue the expected completion, wait for it, then release that request.
   task automatic txn(input int o, input int e);
      sb_q.push_back(o * 2 + e);
      wait_done(60);
      req[o] = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sync_en"}, int'(sync_en), 0);
      chk({tag, "_sync_d"},  int'(sync_d), 0);
      chk({tag, "_busy"},    int'(busy), 0);
      chk({tag, "_owner"},   int'(owner), 0);
      chk({tag, "_done"},    int'(done), 0);
      chk({tag, "_stuck"},   int'(stuck), 0);
   endtask

   initial begin
      bit seen;
      int snap;
      RST = 1'b1; req = 4'b0000; ack = 1'b0; mode = 1;
      repeat (3) tick();
      chk_all_zero("reset");
      RST = 1'b0;
      tick();

      // Single requester, echoed ack.
      mode = 0; en_cnt = 0;
      req = 4'b0010;
      txn(1, 0);
      chk("single_en_pulses", en_cnt, 2);

      // Pointer now 2: 2 before 0.
      req = 4'b0101;
      txn(2, 0);
      txn(0, 0);

      // Reset in WAIT_HI.
      mode = 1;
      req = 4'b1000;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (busy) seen = 1'b1;
      end
      chk("rst_mid_busy", int'(seen), 1);
      tick(); tick();
      chk("rst_mid_sync_d_pre", int'(sync_d), 1);
      RST = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      req = 4'b0000;
      tick();
      RST = 1'b0;
      tick();

      // Round robin from pointer 0.
      mode = 0;
      req = 4'b1111;
      txn(0, 0);
      txn(1, 0);
      txn(2, 0);
      txn(3, 0);
      req = 4'b0001;
      sb_q.push_back(0);
      wait_done(60);
      req = 4'b1001;
      txn(3, 0);
      txn(0, 0);

      // Early ack in IDLE and RAISE is ignored.
      mode = 3; ack = 1'b1;
      tick(); tick();
      chk("spur_idle_busy", int'(busy), 0);
      sb_q.push_back(2);
      req = 4'b0010;
      tick();           // RAISE
      tick();           // WAIT_HI
      ack = 1'b0;
      tick(); tick();
      chk("spur_wait_sync_d", int'(sync_d), 1);
      chk("spur_wait_busy", int'(busy), 1);
      chk("spur_wait_en", int'(sync_en), 0);
      ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (!sync_d) seen = 1'b1;
      end
      chk("spur_drop_seen", int'(seen), 1);
      ack = 1'b0;
      wait_done(20);
      req[1] = 1'b0;

      // Ack-high timeout.
      mode = 1;
      hi_cnt = 0;
      req = 4'b0100;
      txn(2, 1);
      chk("to_wait_hi_cycles", hi_cnt, TO);
      chk("to_stuck", int'(stuck), 0);

      // Stuck ack: goes high once and never returns.
      ack = 1'b0; mode = 2;
      req = 4'b1000;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (stuck) seen = 1'b1;
      end
      chk("stuck_set", int'(seen), 1);
      chk("stuck_busy", int'(busy), 1);
      chk("stuck_sync_d", int'(sync_d), 0);
      chk("stuck_owner", int'(owner), 3);
      req = 4'b1111;
      snap = en_cnt;
      repeat (20) tick();
      chk("stuck_no_grant", en_cnt, snap);
      chk("stuck_hold", int'(stuck), 1);
      chk("stuck_busy_hold", int'(busy), 1);
      RST = 1'b1;
      #1;
      chk("stuck_rst_clear", int'(stuck), 0);
      chk("stuck_rst_busy", int'(busy), 0);
      req = 4'b0000;
      tick();
      RST = 1'b0;
      tick();

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
